// File: rtl/ysyx_220053_mc_controller.sv
// Multi-cycle NPC control unit: FETCH/DECODE/MEM/WB sequencer, RV64I decode, trap halting.
// Optional perf counters are enabled by defining YSYX_220053_CTRL_PERF_EN.
module ysyx_220053_mc_controller #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     instr_i,
  input  logic            br_taken,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            alu_src_b,
  output logic [2:0]      ext_op,
  output logic [1:0]      wb_sel,
  output logic            reg_wen,
  output logic            pc_wen,
  output logic            pc_sel,
  output logic            halt,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] cyc_cnt,
  output logic [XLEN-1:0] inst_cnt
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_IMM32  = 7'b0011011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_OP32   = 7'b0111011;
  localparam logic [31:0] EBREAK    = 32'h00100073;
  localparam logic [15:0] TMO       = 16'(MEM_TIMEOUT);

  state_t      r_state, w_next;
  logic [31:0] r_ir;
  logic [15:0] r_tmo;
  logic [1:0]  r_cause, w_cause;
  logic        r_src_b, r_we;
  logic [2:0]  r_ext;
  logic [1:0]  r_wb_sel;
  logic        w_src_b, w_we, w_mem, w_bad;
  logic [2:0]  w_ext;
  logic [1:0]  w_wb_sel;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;

  assign w_opc = r_ir[6:0];
  assign w_f3  = r_ir[14:12];

  always_comb begin
    w_src_b  = 1'b1;
    w_ext    = 3'd0;
    w_wb_sel = 2'd0;
    w_we     = 1'b0;
    w_mem    = 1'b0;
    w_bad    = 1'b0;
    case (w_opc)
      OP_LUI, OP_AUIPC: w_ext = 3'd1;
      OP_JAL: begin
        w_ext    = 3'd4;
        w_wb_sel = 2'd2;
      end
      OP_JALR: begin
        w_wb_sel = 2'd2;
        w_bad    = (w_f3 != 3'b000);
      end
      OP_LOAD: begin
        w_wb_sel = 2'd1;
        w_mem    = 1'b1;
        w_bad    = (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_ext = 3'd2;
        w_we  = 1'b1;
        w_mem = 1'b1;
        w_bad = w_f3[2];
      end
      OP_BRANCH: begin
        w_ext   = 3'd3;
        w_src_b = 1'b0;
        w_bad   = (w_f3[2:1] == 2'b01);
      end
      OP_IMM:   w_ext = 3'd0;
      OP_IMM32: w_bad = !(w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101);
      OP_OP: begin
        w_ext   = 3'd5;
        w_src_b = 1'b0;
      end
      OP_OP32: begin
        w_ext   = 3'd5;
        w_src_b = 1'b0;
        w_bad   = !(w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101);
      end
      default: w_bad = 1'b1;
    endcase
  end

  // SYSTEM decodes as illegal, so ebreak must be tested before w_bad.
  always_comb begin
    w_next   = r_state;
    w_cause  = r_cause;
    if_ready = (r_state == S_FETCH);
    mem_req  = (r_state == S_MEM);
    pc_wen   = (r_state == S_WB);
    halt     = (r_state == S_HALT);
    reg_wen  = (r_state == S_WB) && (w_opc != OP_BRANCH) && (w_opc != OP_STORE)
               && (r_ir[11:7] != 5'd0);
    pc_sel   = (r_state == S_WB) && ((w_opc == OP_JAL) || (w_opc == OP_JALR)
               || ((w_opc == OP_BRANCH) && br_taken));
    case (r_state)
      S_FETCH:  if (if_valid) w_next = S_DECODE;
      S_DECODE: begin
        if (r_ir == EBREAK) begin
          w_next  = S_HALT;
          w_cause = 2'd1;
        end else if (w_bad) begin
          w_next  = S_HALT;
          w_cause = 2'd2;
        end else if (w_mem) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_next = S_WB;
        end else if (r_tmo == TMO) begin
          w_next  = S_HALT;
          w_cause = 2'd3;
        end
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_ir     <= '0;
      r_tmo    <= '0;
      r_cause  <= '0;
      r_src_b  <= 1'b0;
      r_we     <= 1'b0;
      r_ext    <= '0;
      r_wb_sel <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      r_tmo   <= (r_state == S_MEM) ? r_tmo + 16'd1 : '0;
      if (r_state == S_FETCH && if_valid) r_ir <= instr_i;
      if (r_state == S_DECODE) begin
        r_src_b  <= w_src_b;
        r_we     <= w_we;
        r_ext    <= w_ext;
        r_wb_sel <= w_wb_sel;
      end
    end
  end

  assign alu_src_b  = r_src_b;
  assign mem_we     = r_we;
  assign ext_op     = r_ext;
  assign wb_sel     = r_wb_sel;
  assign trap_cause = r_cause;

`ifdef YSYX_220053_CTRL_PERF_EN
  logic [XLEN-1:0] r_cyc, r_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else begin
      if (r_state != S_HALT) r_cyc <= r_cyc + XLEN'(1);
      if (r_state == S_WB) r_inst <= r_inst + XLEN'(1);
    end
  end

  assign cyc_cnt  = r_cyc;
  assign inst_cnt = r_inst;
`else
  assign cyc_cnt  = '0;
  assign inst_cnt = '0;
`endif
endmodule
